// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator block and datapath logic that must line up with it.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package accum_pkg;

    // Input-beat-to-result delay in clock edges; delay pipelines running
    // alongside the accumulator should be sized from this.
    localparam int ACCUM_LATENCY = 3;

    // Per-beat control bits carried down the pipeline with the data.
    typedef struct packed {
        logic accum;
        logic last;
    } beat_ctl_t;

endpackage

// File: rtl/accum_mem.sv
// Simple dual-port accumulator storage, DEPTH x DATAW, one write port and one read port.
// Latency: synchronous read, data valid one cycle after rd_addr is sampled.
// Backpressure: none; a read and a write may be issued every cycle, same-address read returns old data.
module accum_mem #(
    parameter int DATAW = 32,
    parameter int DEPTH = 512,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [DATAW-1:0] wr_dat,
    input  logic [ADDRW-1:0] rd_addr,
    output logic [DATAW-1:0] rd_dat
);

    logic [DATAW-1:0] mem [DEPTH];

    // Write and registered read share the edge; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/accum.sv
// Per-address accumulator: adds each beat into a stored entry (or restarts it) and emits the sum on the last beat.
// Latency: fixed ACCUM_LATENCY (3) edges from a sampled last beat to o_valid.
// Backpressure: none; one beat accepted every cycle, same-address beats at full rate via S2 forwarding.
module accum
    import accum_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int DEPTH = 512,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [DATAW-1:0] i_data,
    input  logic [ADDRW-1:0] i_addr,
    input  logic             i_accum,
    input  logic             i_last,
    output logic             o_valid,
    output logic [DATAW-1:0] o_result
);

    // S1: registered beat, RAM read in flight
    logic             s1_vld;
    beat_ctl_t        s1_ctl;
    logic [ADDRW-1:0] s1_addr;
    logic [DATAW-1:0] s1_dat;

    // S2: committed sum, mirrors what was written to the RAM at the same edge
    logic             s2_vld;
    logic             s2_last;
    logic [ADDRW-1:0] s2_addr;
    logic [DATAW-1:0] s2_sum;

    logic [DATAW-1:0] rd_dat;
    logic [DATAW-1:0] fwd_dat;
    logic [DATAW-1:0] sum_dat;
    logic             fwd_hit;
    logic             wr_en;

    // Capture the incoming beat; only the valid bit needs clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= i_valid;
        end
        s1_ctl  <= '{accum: i_accum, last: i_last};
        s1_addr <= i_addr;
        s1_dat  <= i_data;
    end

    // Pick the freshest entry value and form the new sum. The RAM returns old data when
    // the previous beat wrote the same address on the read edge, so take S2's sum then.
    always_comb begin
        fwd_hit = s2_vld && (s2_addr == s1_addr);
        fwd_dat = fwd_hit ? s2_sum : rd_dat;
        sum_dat = (s1_ctl.accum ? fwd_dat : '0) + s1_dat;
        // A beat caught by reset must not reach the RAM on the reset edge.
        wr_en   = s1_vld && !rst;
    end

    accum_mem #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (s1_addr),
        .wr_dat  (sum_dat),
        .rd_addr (i_addr),
        .rd_dat  (rd_dat)
    );

    // Register the sum alongside the RAM write so it can be forwarded to the next beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
        end
        s2_last <= s1_ctl.last;
        s2_addr <= s1_addr;
        s2_sum  <= sum_dat;
    end

    // Output register: pulse on last beats, result holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= s2_vld && s2_last;
            if (s2_vld && s2_last) begin
                o_result <= s2_sum;
            end
        end
    end

endmodule

// File: tb/tb_accum.sv
module tb_accum;

    localparam int DATAW = 32;
    localparam int DEPTH = 512;
    localparam int ADDRW = 9;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic [DATAW-1:0] i_data;
    logic [ADDRW-1:0] i_addr;
    logic             i_accum;
    logic             i_last;
    logic             o_valid;
    logic [DATAW-1:0] o_result;

    int total;
    int bad;

    accum #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_addr   (i_addr),
        .i_accum  (i_accum),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d,
                         input logic acc, input logic last);
        i_valid = v;
        i_addr  = a;
        i_data  = d;
        i_accum = acc;
        i_last  = last;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_vld(input string tag, input logic expv);
        total++;
        assert (o_valid === expv) else begin
            bad++;
            $error("FAIL %s o_valid got=%b want=%b", tag, o_valid, expv);
        end
    endtask

    task automatic chk_res(input string tag, input logic [DATAW-1:0] expr);
        total++;
        assert (o_result === expr) else begin
            bad++;
            $error("FAIL %s o_result got=%0h want=%0h", tag, o_result, expr);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        repeat (3) tick();
        chk_vld("reset_vld", 1'b0);
        chk_res("reset_res", 32'd0);
        rst = 1'b0;

        // Single beat: result three edges after sampling.
        drive(1'b1, 9'd5, 32'd7, 1'b0, 1'b1);
        tick(); idle();
        chk_vld("single_e0", 1'b0);
        tick();
        chk_vld("single_e1", 1'b0);
        tick();
        chk_vld("single_e2", 1'b1);
        chk_res("single_res", 32'd7);
        tick();
        chk_vld("single_after", 1'b0);
        chk_res("single_hold", 32'd7);

        // Back-to-back same address: 10 + 20 + 30.
        drive(1'b1, 9'd3, 32'd10, 1'b0, 1'b0);
        tick();
        chk_vld("b2b_a", 1'b0);
        drive(1'b1, 9'd3, 32'd20, 1'b1, 1'b0);
        tick();
        chk_vld("b2b_b", 1'b0);
        drive(1'b1, 9'd3, 32'd30, 1'b1, 1'b1);
        tick(); idle();
        chk_vld("b2b_c", 1'b0);
        tick();
        chk_vld("b2b_d", 1'b0);
        tick();
        chk_vld("b2b_out", 1'b1);
        chk_res("b2b_res", 32'd60);
        tick();
        chk_vld("b2b_after", 1'b0);

        // Interleaved addresses: 5+6=11 then 100-1=99 on consecutive cycles.
        drive(1'b1, 9'd1, 32'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9'd2, 32'd100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 9'd1, 32'd6, 1'b1, 1'b1);
        tick();
        chk_vld("intl_a", 1'b0);
        drive(1'b1, 9'd2, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick(); idle();
        chk_vld("intl_b", 1'b0);
        tick();
        chk_vld("intl_out1", 1'b1);
        chk_res("intl_res1", 32'd11);
        tick();
        chk_vld("intl_out2", 1'b1);
        chk_res("intl_res2", 32'd99);
        tick();
        chk_vld("intl_after", 1'b0);
        chk_res("intl_hold", 32'd99);

        // Gapped reuse with wrap: 0xFFFFFFFF + 2 = 1.
        drive(1'b1, 9'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick(); idle();
        tick();
        tick();
        chk_vld("gap_idle", 1'b0);
        drive(1'b1, 9'd4, 32'd2, 1'b1, 1'b1);
        tick(); idle();
        tick();
        chk_vld("gap_e1", 1'b0);
        tick();
        chk_vld("gap_out", 1'b1);
        chk_res("gap_res", 32'd1);

        // Restart ignores stored value.
        drive(1'b1, 9'd4, 32'd9, 1'b0, 1'b1);
        tick(); idle();
        tick();
        tick();
        chk_vld("restart_out", 1'b1);
        chk_res("restart_res", 32'd9);
        tick();

        // Reset mid-flight: preload addr 0 = 100, then a last beat of 8 that reset must kill.
        drive(1'b1, 9'd0, 32'd100, 1'b0, 1'b0);
        tick(); idle();
        tick();
        tick();
        drive(1'b1, 9'd0, 32'd8, 1'b0, 1'b1);
        tick(); idle();
        rst = 1'b1;
        tick();
        chk_vld("rst_e1_vld", 1'b0);
        chk_res("rst_e1_res", 32'd0);
        tick();
        chk_vld("rst_e2_vld", 1'b0);
        chk_res("rst_e2_res", 32'd0);
        tick();
        chk_vld("rst_e3_vld", 1'b0);
        chk_res("rst_e3_res", 32'd0);
        rst = 1'b0;
        // First cycle after reset: accumulate onto addr 0, which must still hold 100.
        drive(1'b1, 9'd0, 32'd0, 1'b1, 1'b1);
        tick();
        chk_vld("post_a", 1'b0);
        drive(1'b1, 9'd0, 32'd2, 1'b0, 1'b1);
        tick(); idle();
        chk_vld("post_b", 1'b0);
        tick();
        chk_vld("post_out1", 1'b1);
        chk_res("post_nowrite", 32'd100);
        tick();
        chk_vld("post_out2", 1'b1);
        chk_res("post_res", 32'd2);
        tick();
        chk_vld("post_after", 1'b0);
        chk_res("post_hold", 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
